// File: rtl/note_lookup_sequencer.sv
// Frequency-to-note lookup: binary search over an external synchronous boundary
// ROM, followed by a frame-stability / silence-hold filter on the result.
module note_lookup_sequencer #(
  parameter int unsigned FREQ_W      = 16,
  parameter int unsigned IDX_W       = 7,
  parameter int unsigned NUM_NOTES   = 120,
  parameter int unsigned STABLE_CNT  = 3,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              freq_req,
  output logic              freq_ready,
  output logic              rom_rd,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [FREQ_W-1:0] rom_data,
  output logic              done,
  output logic              silent,
  output logic [IDX_W-1:0]  note_idx,
  output logic [3:0]        octave,
  output logic [3:0]        semitone,
  output logic [IDX_W-1:0]  stable_idx,
  output logic              stable_valid
);

  localparam int unsigned CNT_W     = $clog2(STABLE_CNT + 1);
  localparam int unsigned SIL_W     = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned SUM_W     = IDX_W + 1;
  localparam int unsigned OCT_STEPS = (NUM_NOTES - 1) / 12;
  localparam logic [IDX_W-1:0] TOP_ADDR = IDX_W'(NUM_NOTES);
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NUM_NOTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_CMP_LO, S_RD_HI, S_CMP_HI, S_RD_MID, S_CMP_MID, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [FREQ_W-1:0]  f_q, f_d;
  logic [IDX_W-1:0]   lo_q, lo_d, hi_q, hi_d, res_q, res_d;
  logic               frame_silent_q, frame_silent_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIL_W-1:0]   sil_cnt_q, sil_cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic               ready_d, rom_rd_d, done_d, silent_d, sval_d;
  logic [IDX_W-1:0]   rom_addr_d, note_idx_d, sidx_d;
  logic [3:0]         octave_d, semitone_d;

  logic               ge_rom;
  logic [IDX_W-1:0]   lo_m, hi_m, mid_nx;
  logic               span_one;
  logic [IDX_W-1:0]   rem;
  logic [3:0]         oct;

  // Search step: compare against the boundary read last cycle and narrow [lo, hi)
  always_comb begin
    ge_rom   = (f_q >= rom_data);
    lo_m     = ge_rom ? rom_addr : lo_q;
    hi_m     = ge_rom ? hi_q : rom_addr;
    span_one = ((hi_m - lo_m) == IDX_W'(1));
    mid_nx   = IDX_W'((SUM_W'(lo_m) + SUM_W'(hi_m)) >> 1);
  end

  // Octave/semitone of the held result by repeated compare-subtract
  always_comb begin
    rem = res_q;
    oct = 4'd0;
    for (int i = 0; i < int'(OCT_STEPS); i++) begin
      if (rem >= IDX_W'(12)) begin
        rem = rem - IDX_W'(12);
        oct = oct + 4'd1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (freq_req) state_nx = (freq_in == '0) ? S_DONE : S_RD_LO;
      S_RD_LO:   state_nx = S_CMP_LO;
      S_CMP_LO:  state_nx = ge_rom ? S_RD_HI : S_DONE;
      S_RD_HI:   state_nx = S_CMP_HI;
      S_CMP_HI:  state_nx = ge_rom ? S_DONE : S_RD_MID;
      S_RD_MID:  state_nx = S_CMP_MID;
      S_CMP_MID: state_nx = span_one ? S_DONE : S_RD_MID;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Next values of datapath, ROM port, result and filter registers
  always_comb begin
    f_d            = f_q;
    lo_d           = lo_q;
    hi_d           = hi_q;
    res_d          = res_q;
    frame_silent_d = frame_silent_q;
    rom_rd_d       = 1'b0;
    rom_addr_d     = rom_addr;
    ready_d        = (state_nx == S_IDLE);
    done_d         = 1'b0;
    silent_d       = silent;
    note_idx_d     = note_idx;
    octave_d       = octave;
    semitone_d     = semitone;
    cnt_d          = cnt_q;
    sil_cnt_d      = sil_cnt_q;
    last_d         = last_q;
    sidx_d         = stable_idx;
    sval_d         = stable_valid;
    case (state)
      S_IDLE: begin
        if (freq_req) begin
          f_d = freq_in;
          if (freq_in == '0) begin
            frame_silent_d = 1'b1;
            res_d          = '0;
          end else begin
            frame_silent_d = 1'b0;
            rom_rd_d       = 1'b1;
            rom_addr_d     = '0;
          end
        end
      end
      S_CMP_LO: begin
        if (!ge_rom) begin
          res_d = '0;
        end else begin
          lo_d       = '0;
          rom_rd_d   = 1'b1;
          rom_addr_d = TOP_ADDR;
        end
      end
      S_CMP_HI: begin
        if (ge_rom) begin
          res_d = TOP_IDX;
        end else begin
          hi_d       = TOP_ADDR;
          rom_rd_d   = 1'b1;
          rom_addr_d = IDX_W'((SUM_W'(lo_q) + SUM_W'(TOP_ADDR)) >> 1);
        end
      end
      S_CMP_MID: begin
        lo_d = lo_m;
        hi_d = hi_m;
        if (span_one) begin
          res_d = lo_m;
        end else begin
          rom_rd_d   = 1'b1;
          rom_addr_d = mid_nx;
        end
      end
      S_DONE: begin
        done_d     = 1'b1;
        silent_d   = frame_silent_q;
        note_idx_d = res_q;
        octave_d   = oct;
        semitone_d = rem[3:0];
        if (frame_silent_q) begin
          cnt_d = '0;
          if (sil_cnt_q < SIL_W'(HOLD_FRAMES)) sil_cnt_d = sil_cnt_q + SIL_W'(1);
          if (sil_cnt_d == SIL_W'(HOLD_FRAMES)) sval_d = 1'b0;
        end else begin
          sil_cnt_d = '0;
          if (res_q == last_q) begin
            if (cnt_q < CNT_W'(STABLE_CNT)) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            last_d = res_q;
            cnt_d  = CNT_W'(1);
          end
          if (cnt_d == CNT_W'(STABLE_CNT)) begin
            sidx_d = res_q;
            sval_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      f_q            <= '0;
      lo_q           <= '0;
      hi_q           <= '0;
      res_q          <= '0;
      frame_silent_q <= 1'b0;
      cnt_q          <= '0;
      sil_cnt_q      <= '0;
      last_q         <= '0;
      freq_ready     <= 1'b1;
      rom_rd         <= 1'b0;
      rom_addr       <= '0;
      done           <= 1'b0;
      silent         <= 1'b0;
      note_idx       <= '0;
      octave         <= 4'd0;
      semitone       <= 4'd0;
      stable_idx     <= '0;
      stable_valid   <= 1'b0;
    end else begin
      f_q            <= f_d;
      lo_q           <= lo_d;
      hi_q           <= hi_d;
      res_q          <= res_d;
      frame_silent_q <= frame_silent_d;
      cnt_q          <= cnt_d;
      sil_cnt_q      <= sil_cnt_d;
      last_q         <= last_d;
      freq_ready     <= ready_d;
      rom_rd         <= rom_rd_d;
      rom_addr       <= rom_addr_d;
      done           <= done_d;
      silent         <= silent_d;
      note_idx       <= note_idx_d;
      octave         <= octave_d;
      semitone       <= semitone_d;
      stable_idx     <= sidx_d;
      stable_valid   <= sval_d;
    end
  end

endmodule

// File: tb/tb_note_lookup_sequencer.sv
// Bench for note_lookup_sequencer: boundary ROM model, frame-level reference
// model with per-cycle compare, and directed frames with literal expectations.
module tb_note_lookup_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] freq_in;
  logic        freq_req;
  logic        freq_ready;
  logic        rom_rd;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        done;
  logic        silent;
  logic [6:0]  note_idx;
  logic [3:0]  octave;
  logic [3:0]  semitone;
  logic [6:0]  stable_idx;
  logic        stable_valid;

  note_lookup_sequencer dut (
    .clk(clk), .resetn(resetn), .freq_in(freq_in), .freq_req(freq_req),
    .freq_ready(freq_ready), .rom_rd(rom_rd), .rom_addr(rom_addr),
    .rom_data(rom_data), .done(done), .silent(silent), .note_idx(note_idx),
    .octave(octave), .semitone(semitone), .stable_idx(stable_idx),
    .stable_valid(stable_valid)
  );

  always #5 clk = ~clk;

  logic [15:0] bound [0:120];
  logic [6:0]  rd_log [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // frame in flight and reference filter state
  int   pending = 0;
  int   due = 0;
  int   acc_cyc = 0;
  int   m_f = 0;
  int   meas_lat = 0;
  int   done_cnt = 0;
  int   m_last = 0, m_cnt = 0, m_sil = 0, m_sidx = 0, m_sval = 0;
  logic exp_done;
  int   e_idx;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous boundary ROM
  always @(posedge clk) begin
    if (rom_rd) begin
      rom_data <= (rom_addr <= 7'd120) ? bound[rom_addr] : 16'd0;
      rd_log.push_back(rom_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // largest boundary index not above f, clamped to the note range
  function automatic int ref_idx(input int f);
    for (int i = 120; i >= 0; i--)
      if (int'(bound[i]) <= f) return (i > 119) ? 119 : i;
    return 0;
  endfunction

  // accept-to-done latency: clamps are fixed, a search costs two cycles per probe
  function automatic int ref_lat(input int f);
    int lo, hi, mid, k;
    if (f == 0) return 1;
    if (f < int'(bound[0])) return 3;
    if (f >= int'(bound[120])) return 5;
    lo = 0; hi = 120; k = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (f >= int'(bound[mid])) lo = mid; else hi = mid;
      k++;
    end
    return 5 + 2 * k;
  endfunction

  // per-cycle compare of DUT outputs against the reference model
  always @(negedge clk) begin
    if (resetn) begin
      exp_done = (pending != 0) && (cyc == due);
      chk("done", done, exp_done);
      chk("freq_ready", freq_ready, (pending == 0) || (cyc >= due));
      if (pending == 0) chk("rom_rd_idle", rom_rd, 0);
      if (done) begin
        meas_lat = cyc - acc_cyc;
        done_cnt++;
      end
      if (exp_done) begin
        chk("silent", silent, m_f == 0);
        if (m_f == 0) begin
          m_cnt = 0;
          if (m_sil < 8) m_sil++;
          if (m_sil == 8) m_sval = 0;
        end else begin
          e_idx = ref_idx(m_f);
          chk("note_idx", note_idx, e_idx);
          chk("octave", octave, e_idx / 12);
          chk("semitone", semitone, e_idx % 12);
          m_sil = 0;
          if (e_idx == m_last) begin
            if (m_cnt < 3) m_cnt++;
          end else begin
            m_last = e_idx;
            m_cnt = 1;
          end
          if (m_cnt == 3) begin
            m_sidx = e_idx;
            m_sval = 1;
          end
        end
        pending = 0;
      end
      chk("stable_valid", stable_valid, m_sval);
      chk("stable_idx", stable_idx, m_sidx);
    end
  end

  task automatic accept(input logic [15:0] f);
    int n;
    n = 0;
    @(negedge clk);
    while (!freq_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!freq_ready) chk("accept_timeout", 0, 1);
    freq_in  = f;
    freq_req = 1'b1;
    @(posedge clk);
    #1;
    freq_req = 1'b0;
    rd_log.delete();
    m_f     = int'(f);
    acc_cyc = cyc;
    due     = cyc + ref_lat(int'(f));
    pending = 1;
  endtask

  task automatic send_frame(input logic [15:0] f);
    int n;
    accept(f);
    n = 0;
    while (pending != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (pending != 0) begin
      chk("done_timeout", 0, 1);
      pending = 0;
    end
  endtask

  task automatic clear_model();
    pending = 0; m_last = 0; m_cnt = 0; m_sil = 0; m_sidx = 0; m_sval = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rom_rd"}, rom_rd, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_ready"}, freq_ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_silent"}, silent, 0);
    chk({tag, "_note_idx"}, note_idx, 0);
    chk({tag, "_octave"}, octave, 0);
    chk({tag, "_semitone"}, semitone, 0);
    chk({tag, "_stable_idx"}, stable_idx, 0);
    chk({tag, "_stable_valid"}, stable_valid, 0);
  endtask

  int stab_f  [6] = '{440, 440, 300, 440, 440, 440};
  int stab_sv [6] = '{0, 0, 0, 0, 0, 1};
  int n_wait;
  int d0;

  initial begin
    real r12, r24, b;
    r12 = 1.0594630943592953;
    r24 = 1.0293022366434921;
    b = 440.0;
    for (int i = 0; i < 57; i++) b = b / r12;
    b = b / r24;
    for (int i = 0; i <= 120; i++) begin
      bound[i] = 16'($rtoi(b));
      b = b * r12;
    end

    resetn = 1'b0; freq_req = 1'b0; freq_in = 16'd0;
    repeat (3) @(negedge clk);
    chk_reset_values("rst_hold");
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_values("rst_rel");

    // stability filter: valid only after three identical results in a row
    for (int i = 0; i < 6; i++) begin
      send_frame(16'(stab_f[i]));
      chk("stab_valid_lit", stable_valid, stab_sv[i]);
    end
    chk("stab_idx_lit", stable_idx, 57);
    for (int i = 0; i < 8; i++) begin
      send_frame(16'd0);
      chk("hold_valid_lit", stable_valid, (i < 7) ? 1 : 0);
      chk("hold_silent_lit", silent, 1);
      chk("hold_lat_lit", meas_lat, 1);
    end
    chk("hold_idx_kept", stable_idx, 57);

    // normal lookups around the A4 boundary
    send_frame(16'd440);
    chk("a440_idx", note_idx, 57);
    chk("a440_oct", octave, 4);
    chk("a440_sem", semitone, 9);
    chk("a440_lat", meas_lat <= 19, 1);
    send_frame(16'd427);
    chk("f427_idx", note_idx, 57);
    send_frame(16'd426);
    chk("f426_idx", note_idx, 56);
    chk("f426_sem", semitone, 8);

    // clamps
    send_frame(16'd10);
    chk("lo_idx", note_idx, 0);
    chk("lo_lat", meas_lat, 3);
    chk("lo_reads", rd_log.size(), 1);
    if (rd_log.size() >= 1) chk("lo_addr0", rd_log[0], 0);
    send_frame(16'd30000);
    chk("hi_idx", note_idx, 119);
    chk("hi_oct", octave, 9);
    chk("hi_sem", semitone, 11);
    chk("hi_lat", meas_lat, 5);
    chk("hi_reads", rd_log.size(), 2);
    if (rd_log.size() >= 2) begin
      chk("hi_addr0", rd_log[0], 0);
      chk("hi_addr1", rd_log[1], 120);
    end

    // request while busy is dropped
    d0 = done_cnt;
    fork
      send_frame(16'd440);
      begin
        repeat (5) @(negedge clk);
        chk("busy_ready", freq_ready, 0);
        freq_in  = 16'd1000;
        freq_req = 1'b1;
        @(negedge clk);
        freq_req = 1'b0;
      end
    join
    repeat (25) @(negedge clk);
    chk("busy_done_count", done_cnt - d0, 1);
    chk("busy_idx", note_idx, 57);

    // reset in the middle of a search
    repeat (3) send_frame(16'd440);
    chk("pre_rst_valid", stable_valid, 1);
    accept(16'd440);
    n_wait = 0;
    while (!(rom_rd && rom_addr != 7'd0 && rom_addr != 7'd120) && n_wait < 30) begin
      @(negedge clk);
      n_wait++;
    end
    chk("rd_mid_seen", n_wait < 30, 1);
    resetn = 1'b0;
    clear_model();
    #1;
    chk_reset_values("rst_mid");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (25) @(negedge clk);
    chk_reset_values("rst_after");
    send_frame(16'd440);
    chk("post_rst_idx", note_idx, 57);
    chk("post_rst_valid", stable_valid, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
